// File: rtl/imm_ext_stage.sv
// imm_ext_stage: registered immediate generator with a 2-entry skid buffer (main + skid).
// Define IMM_CSR_ZIMM_EN to decode imm_src 101 as the zero-extended CSR zimm.
module imm_ext_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [2:0]      imm_src,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] imm_ext,
   output logic            out_illegal
);
   logic [31:0]     raw;
   logic            newIllegal;
   logic [XLEN-1:0] newImm;
   logic [XLEN-1:0] mainImm, skidImm;
   logic            mainIll, skidIll, mainValid, skidValid;
   logic            accept, consume;
   logic            unusedOpcode;
   assign unusedOpcode = &instr[6:0];
   always_comb begin
      raw = '0;
      newIllegal = 1'b0;
      case (imm_src)
         3'b000: raw = {{20{instr[31]}}, instr[31:20]};
         3'b001: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         3'b010: raw = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         3'b011: raw = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         3'b100: raw = {instr[31:12], 12'b0};
`ifdef IMM_CSR_ZIMM_EN
         3'b101: raw = {27'b0, instr[19:15]};
`endif
         default: newIllegal = 1'b1;
      endcase
   end
   // Every 32-bit form is already sign-correct, so widening to RV64 is a plain sign extension.
   assign newImm   = XLEN'($signed(raw));
   assign accept   = in_valid && in_ready;
   assign consume  = mainValid && out_ready;
   assign in_ready = !skidValid;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainImm   <= '0;
         mainIll   <= 1'b0;
         mainValid <= 1'b0;
         skidImm   <= '0;
         skidIll   <= 1'b0;
         skidValid <= 1'b0;
      end else if (flush) begin
         mainValid <= 1'b0;
         skidValid <= 1'b0;
      end else if (consume) begin
         if (skidValid) begin
            mainImm   <= skidImm;
            mainIll   <= skidIll;
            skidValid <= 1'b0;
         end else if (accept) begin
            mainImm <= newImm;
            mainIll <= newIllegal;
         end else begin
            mainValid <= 1'b0;
         end
      end else if (accept) begin
         if (!mainValid) begin
            mainImm   <= newImm;
            mainIll   <= newIllegal;
            mainValid <= 1'b1;
         end else begin
            skidImm   <= newImm;
            skidIll   <= newIllegal;
            skidValid <= 1'b1;
         end
      end
   end
   assign out_valid   = mainValid;
   assign imm_ext     = mainImm;
   assign out_illegal = mainIll;
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed vectors on RV32 and RV64 instances sharing one input stream.
module tb_imm_ext_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] instr = '0;
   logic [2:0]  imm_src = '0;
   logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   int          total = 0;
   int          bad = 0;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [63:0] e64;
      logic        ill;
   } vec_t;
   vec_t v[11];

   imm_ext_stage #(.XLEN(32)) d32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32), .instr(instr),
      .imm_src(imm_src), .flush(flush), .out_valid(ov32), .out_ready(out_ready),
      .imm_ext(imm32), .out_illegal(ill32));
   imm_ext_stage #(.XLEN(64)) d64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64), .instr(instr),
      .imm_src(imm_src), .flush(flush), .out_valid(ov64), .out_ready(out_ready),
      .imm_ext(imm64), .out_illegal(ill64));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, a, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [31:0] i, input logic [2:0] s);
      in_valid = vld;
      instr    = i;
      imm_src  = s;
   endtask

   task automatic chkOut(input string n, input logic vld, input logic [63:0] e, input logic ill);
      chk({n, "_valid32"}, 64'(ov32), 64'(vld));
      chk({n, "_valid64"}, 64'(ov64), 64'(vld));
      chk({n, "_imm32"}, 64'(imm32), {32'b0, e[31:0]});
      chk({n, "_imm64"}, imm64, e);
      chk({n, "_ill32"}, 64'(ill32), 64'(ill));
      chk({n, "_ill64"}, 64'(ill64), 64'(ill));
   endtask

   task automatic chkRdy(input string n, input logic r);
      chk({n, "_rdy32"}, 64'(rdy32), 64'(r));
      chk({n, "_rdy64"}, 64'(rdy64), 64'(r));
   endtask

   initial begin
      v[0]  = '{32'hFFF00093, 3'b000, 64'hFFFFFFFFFFFFFFFF, 1'b0};
      v[1]  = '{32'hFE000EE3, 3'b010, 64'hFFFFFFFFFFFFFFFC, 1'b0};
      v[2]  = '{32'h001000EF, 3'b011, 64'h0000000000000800, 1'b0};
      v[3]  = '{32'h800000B7, 3'b100, 64'hFFFFFFFF80000000, 1'b0};
      v[4]  = '{32'h7FF00093, 3'b000, 64'h00000000000007FF, 1'b0};
      v[5]  = '{32'hFE112E23, 3'b001, 64'hFFFFFFFFFFFFFFFC, 1'b0};
`ifdef IMM_CSR_ZIMM_EN
      v[6]  = '{32'h000F8073, 3'b101, 64'h000000000000001F, 1'b0};
`else
      v[6]  = '{32'h000F8073, 3'b101, 64'h0000000000000000, 1'b1};
`endif
      v[7]  = '{32'hFFFFFFFF, 3'b111, 64'h0, 1'b1};
      v[8]  = '{32'hFFFFFFFF, 3'b110, 64'h0, 1'b1};
      v[9]  = '{32'h12345037, 3'b100, 64'h0000000012345000, 1'b0};
      v[10] = '{32'h80000093, 3'b000, 64'hFFFFFFFFFFFFF800, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chkOut("reset", 1'b0, 64'h0, 1'b0);
      chkRdy("reset", 1'b1);
      rst_n = 1'b1;

      // Back-to-back streaming: each entry appears one edge after it is presented.
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, v[i].instr, v[i].src);
         tick();
         chkOut($sformatf("vec%0d", i), 1'b1, v[i].e64, v[i].ill);
      end
      drive(1'b0, '0, '0);
      tick();
      chkOut("drain", 1'b0, v[10].e64, v[10].ill);

      // Backpressure: A and B fill main and skid, C waits at the input.
      out_ready = 1'b0;
      drive(1'b1, 32'h00500093, 3'b000);
      tick();
      chkOut("bpA", 1'b1, 64'd5, 1'b0);
      chkRdy("bpA", 1'b1);
      drive(1'b1, 32'hFE112E23, 3'b001);
      tick();
      chkOut("bpB", 1'b1, 64'd5, 1'b0);
      chkRdy("bpB", 1'b0);
      drive(1'b1, 32'h12345037, 3'b100);
      tick();
      chkOut("bpHold", 1'b1, 64'd5, 1'b0);
      chkRdy("bpHold", 1'b0);
      out_ready = 1'b1;
      tick();
      chkOut("bpOutB", 1'b1, 64'hFFFFFFFFFFFFFFFC, 1'b0);
      chkRdy("bpOutB", 1'b1);
      tick();
      chkOut("bpOutC", 1'b1, 64'h0000000012345000, 1'b0);
      drive(1'b0, '0, '0);
      tick();
      chk("bpEmpty", 64'(ov32 | ov64), 64'd0);

      // Flush with both entries full and a simultaneous incoming entry.
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 3'b000);
      tick();
      drive(1'b1, 32'h00200093, 3'b000);
      tick();
      chkRdy("preFlush", 1'b0);
      drive(1'b1, 32'h00300093, 3'b000);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      chk("flushValid", 64'(ov32 | ov64), 64'd0);
      chkRdy("flush", 1'b1);
      out_ready = 1'b1;
      repeat (2) tick();
      chk("flushStale", 64'(ov32 | ov64), 64'd0);

      // Asynchronous reset between edges.
      out_ready = 1'b0;
      drive(1'b1, 32'hFFF00093, 3'b000);
      tick();
      chkOut("preRst", 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      drive(1'b1, 32'h00700093, 3'b000);
      #2;
      rst_n = 1'b0;
      #1;
      chkOut("asyncRst", 1'b0, 64'h0, 1'b0);
      chkRdy("asyncRst", 1'b1);
      #1;
      rst_n = 1'b1;
      tick();
      chkOut("postRst", 1'b1, 64'd7, 1'b0);
      drive(1'b0, '0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Registered, parametrised immediate-generation stage for the decode pipeline. It takes a fetched instruction word and its control-selected immediate type, and produces the sign-extended immediate at XLEN width. It uses a valid/ready handshake and a 2-entry skid buffer, so decode can stall without dropping immediates. It sits between instruction fetch/control decode and the ID/EX register, and supports RV32 and RV64 datapaths.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instr/imm_src are valid this cycle.
- in_ready  output  1  stage can accept a new entry.
- instr  input  32  raw instruction word; bits [6:0] are ignored.
- imm_src  input  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 CSR zimm (macro only), others illegal.
- flush  input  1  synchronous kill of all held entries (branch mispredict / trap).
- out_valid  output  1  imm_ext/out_illegal are valid.
- out_ready  input  1  downstream consumes the output this cycle.
- imm_ext  output  XLEN  extended immediate.
- out_illegal  output  1  imm_src was unsupported; imm_ext is 0 for this entry.

## Operation
- Extension rules, with s = instr[31] replicated up to XLEN:
  - I: {s, instr[31:20]}.
  - S: {s, instr[31:25], instr[11:7]}.
  - B: {s, instr[7], instr[30:25], instr[11:8], 0}.
  - J: {s, instr[19:12], instr[20], instr[30:21], 0}.
  - U: {s, instr[31:12], 12'b0}. For XLEN=64 the upper 32 bits copy bit 31 (RV64 LUI/AUIPC semantics).
- Bit 0 is forced to 0 for B and J. The low bit is kept addressable for a future C extension; no half-word shifting is applied.
- Storage is a main register (output) plus a skid register, each holding {imm, illegal, valid}.
- An accept occurs when in_valid && in_ready. A consume occurs when out_valid && out_ready.
- On accept, the computed entry goes to the main register if it is empty or being consumed in the same cycle; otherwise it goes to the skid register.
- On consume with the skid register full, skid moves to main and skid empties.
- in_ready = !skid_valid, registered state only. There is no combinational path from out_ready to in_ready.
- Ordering is strictly FIFO; entries are never dropped or duplicated.
- Illegal imm_src: the entry is accepted normally with imm_ext=0 and out_illegal=1.
- flush: both valid bits clear on the next edge. Flush beats a simultaneous accept (the incoming entry is discarded) and a simultaneous consume.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is on imm_ext with out_valid=1 after edge N.
- Throughput is 1 entry per cycle while out_ready=1.
- Reset values: out_valid=0, imm_ext=0, out_illegal=0, in_ready=1, skid empty.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first accept is possible on the first edge after rst_n rises.
- While out_valid=1 and out_ready=0, imm_ext and out_illegal hold stable.
- Full condition (both registers valid): in_ready=0, and in_valid is ignored.
- Simultaneous accept and consume with skid full cannot occur, because in_ready=0 in that state.

## Configuration
- IMM_CSR_ZIMM_EN:
  - Defined: imm_src 101 yields the zero-extended zimm {0, instr[19:15]} for CSRRWI/CSRRSI/CSRRCI, with out_illegal=0.
  - Undefined: 101 is treated as illegal, like 110 and 111.

## Test plan
- XLEN=32, I-type: instr 0xFFF00093 (addi x1,x0,-1), src 000 → imm_ext 0xFFFFFFFF one cycle later, out_illegal=0.
- B-type and J-type: 0xFE000EE3 with src 010 → 0xFFFFFFFC. 0x001000EF with src 011 → 0x00000800. Both back to back, out_ready=1, one result per cycle in order.
- XLEN=64, U-type: 0x800000B7 with src 100 → 0xFFFFFFFF80000000. I-type 0x7FF00093 → 0x00000000000007FF.
- Backpressure, out_ready=0:
  - Push A=I(0x00500093→5), then B=S(0xFE112E23→0xFFFFFFFC). in_ready drops to 0 after B; C is held at the input.
  - Raise out_ready: outputs are 5, then −4, then C, with no loss.
- Flush: with both entries full, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and no stale entry appears. Separately, drive rst_n low mid-stream → outputs are 0 asynchronously.
- Config: src 101 with instr[19:15]=11111 → 0x1F, out_illegal=0 when IMM_CSR_ZIMM_EN is defined; imm 0 with out_illegal=1 when it is not. src 111 always → out_illegal=1.
